// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM pipeline stage controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int FLAG_W      = 3;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_REG_W   = 4;
  localparam int DEF_TIMEOUT = 8;

  // A load or store only counts when EX/MEM holds a real instruction.
  function automatic logic is_mem_op(input logic valid, input logic rd, input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_stage_timer.sv
// Clearable WAIT-cycle counter; expired is high during the TIMEOUT-th counted cycle.
module mem_stage_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds completed WAIT cycles, so the current cycle is number cnt+1.
  assign expired = en && (cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage controller: req/ack data-memory access with timeout, upstream stall and MEM/WB bubbles.
// Optional build macro MEM_STALL_CNT_EN adds a saturating stall_cnt output.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_W   = DEF_REG_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [REG_W-1:0]  ex_dst_reg,
  input  logic [FLAG_W-1:0] ex_flags,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_alu_out,
  output logic [DATA_W-1:0] wb_mem_out,
  output logic [REG_W-1:0]  wb_dst_reg,
  output logic              wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic [FLAG_W-1:0] wb_flags,
  output logic              mem_err
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  state_t            state;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_op;
  logic              timed_out;
  logic              is_load;

  assign mem_op  = is_mem_op(ex_valid, ex_mem_read, ex_mem_write);
  // A simultaneous read+write is treated as a store.
  assign is_load = ex_mem_read & ~ex_mem_write;

  mem_stage_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != WAIT),
    .en     (state == WAIT),
    .expired(timed_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_err   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            mem_addr  <= ex_alu_out;
            mem_wdata <= ex_store_data;
            mem_we    <= ex_mem_write;
            mem_req   <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // An ack in the final timeout cycle still completes the access.
          if (mem_ack) begin
            if (!mem_we) begin
              rdata_q <= mem_rdata;
            end
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (timed_out) begin
            mem_err <= 1'b1;
            rdata_q <= '0;
            mem_req <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Gated by rst so an abort releases the upstream freeze in the same cycle.
  assign stall = ~rst & (((state == IDLE) & mem_op) | (state == WAIT));

  // NOTE: every always_comb output gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    wb_valid      = 1'b0;
    wb_alu_out    = '0;
    wb_mem_out    = '0;
    wb_dst_reg    = '0;
    wb_mem_to_reg = 1'b0;
    wb_reg_write  = 1'b0;
    wb_flags      = '0;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          wb_valid     = ex_valid;
          wb_alu_out   = ex_alu_out;
          wb_dst_reg   = ex_dst_reg;
          wb_reg_write = ex_valid & ex_reg_write;
          wb_flags     = ex_flags;
        end
      end
      DONE: begin
        wb_valid      = ex_valid;
        wb_alu_out    = ex_alu_out;
        wb_mem_out    = rdata_q;
        wb_dst_reg    = ex_dst_reg;
        wb_mem_to_reg = ex_valid & is_load;
        wb_reg_write  = ex_valid & ex_reg_write;
        wb_flags      = ex_flags;
      end
      default: begin
      end
    endcase
  end

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, load/store handshakes, timeout and reset abort.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [15:0] ex_alu_out, ex_store_data, mem_rdata;
  logic [3:0]  ex_dst_reg;
  logic [2:0]  ex_flags;
  logic        mem_ack;
  logic        mem_req, mem_we, stall, wb_valid, wb_mem_to_reg, wb_reg_write, mem_err;
  logic [15:0] mem_addr, mem_wdata, wb_alu_out, wb_mem_out;
  logic [3:0]  wb_dst_reg;
  logic [2:0]  wb_flags;
`ifdef MEM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int stall_n, req_n;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_dst_reg(ex_dst_reg), .ex_flags(ex_flags),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .wb_valid(wb_valid), .wb_alu_out(wb_alu_out), .wb_mem_out(wb_mem_out),
    .wb_dst_reg(wb_dst_reg), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_flags(wb_flags), .mem_err(mem_err)
`ifdef MEM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rd, input logic wr, input logic rw,
                        input logic [15:0] alu, input logic [15:0] sd, input logic [3:0] dst,
                        input logic [2:0] fl);
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
    ex_alu_out = alu; ex_store_data = sd; ex_dst_reg = dst; ex_flags = fl;
  endtask

  // Runs from the IDLE cycle of a memory op until the first cycle with stall=0 (DONE).
  // ack_at: cycle index to pulse mem_ack (1 = first WAIT cycle), negative for never.
  task automatic run_mem(input int ack_at, input logic [15:0] rdata,
                         output int s_n, output int r_n);
    s_n = 0; r_n = 0;
    for (int c = 0; c < 40; c++) begin
      mem_ack   = (c == ack_at);
      mem_rdata = rdata;
      #1;
      if (!stall) begin
        mem_ack = 1'b0;
        return;
      end
      s_n++;
      if (mem_req) r_n++;
      tick();
    end
    mem_ack = 1'b0;
    check("done_bound", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 3'h0);
    #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    tick();
    rst = 1'b0;

    // Reset while a load is waiting on memory.
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0, 4'h2, 3'h0);
    tick();
    tick();
    check("wait_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rstwait_req", 32'(mem_req), 32'd0);
    check("rstwait_stall", 32'(stall), 32'd0);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 3'h0);
    rst = 1'b0;
    #1;
    check("rstwait_state", 32'(dut.state), 32'(IDLE));
    check("rstwait_err", 32'(mem_err), 32'd0);

    // ALU op passes through combinationally; stray ack is ignored.
    tick();
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0, 4'd3, 3'b101);
    mem_ack = 1'b1;
    #1;
    check("alu_stall", 32'(stall), 32'd0);
    check("alu_valid", 32'(wb_valid), 32'd1);
    check("alu_out", 32'(wb_alu_out), 32'h1234);
    check("alu_dst", 32'(wb_dst_reg), 32'd3);
    check("alu_rw", 32'(wb_reg_write), 32'd1);
    check("alu_m2r", 32'(wb_mem_to_reg), 32'd0);
    check("alu_flags", 32'(wb_flags), 32'b101);
    tick();
    mem_ack = 1'b0;
    #1;
    check("stray_ack_req", 32'(mem_req), 32'd0);

    // Load, ack in the third WAIT cycle.
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0, 4'd5, 3'b001);
    run_mem(3, 16'hBEEF, stall_n, req_n);
    check("ld_stall_n", 32'(stall_n), 32'd4);
    check("ld_req_n", 32'(req_n), 32'd3);
    check("ld_addr", 32'(mem_addr), 32'h0040);
    check("ld_we", 32'(mem_we), 32'd0);
    check("ld_valid", 32'(wb_valid), 32'd1);
    check("ld_mem_out", 32'(wb_mem_out), 32'hBEEF);
    check("ld_m2r", 32'(wb_mem_to_reg), 32'd1);
    check("ld_dst", 32'(wb_dst_reg), 32'd5);
    check("ld_req_done", 32'(mem_req), 32'd0);
`ifdef MEM_STALL_CNT_EN
    tick();
    check("stall_cnt", 32'(stall_cnt), 32'd4);
`endif

    // Store, ack in the first WAIT cycle.
    tick();
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 16'h00A0, 16'h5555, 4'd0, 3'b000);
    run_mem(1, 16'hDEAD, stall_n, req_n);
    check("st_stall_n", 32'(stall_n), 32'd2);
    check("st_we", 32'(mem_we), 32'd1);
    check("st_wdata", 32'(mem_wdata), 32'h5555);
    check("st_addr", 32'(mem_addr), 32'h00A0);
    check("st_rw", 32'(wb_reg_write), 32'd0);
    check("st_m2r", 32'(wb_mem_to_reg), 32'd0);

    // Read and write together behave as a store.
    tick();
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 16'h00B0, 16'h7777, 4'd1, 3'b000);
    run_mem(1, 16'h0, stall_n, req_n);
    check("rw_we", 32'(mem_we), 32'd1);
    check("rw_m2r", 32'(wb_mem_to_reg), 32'd0);

    // Ack in the final timeout cycle wins.
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 16'h0080, 16'h0, 4'd7, 3'b000);
    run_mem(8, 16'h1357, stall_n, req_n);
    check("late_req_n", 32'(req_n), 32'd8);
    check("late_err", 32'(mem_err), 32'd0);
    check("late_mem_out", 32'(wb_mem_out), 32'h1357);

    // No ack: timeout after eight WAIT cycles.
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 16'h0090, 16'h0, 4'd6, 3'b000);
    run_mem(-1, 16'hFFFF, stall_n, req_n);
    check("to_stall_n", 32'(stall_n), 32'd9);
    check("to_req_n", 32'(req_n), 32'd8);
    check("to_req_done", 32'(mem_req), 32'd0);
    check("to_err", 32'(mem_err), 32'd1);
    check("to_mem_out", 32'(wb_mem_out), 32'h0000);

    // mem_err stays set; a bubble from EX/MEM keeps reg_write low.
    tick();
    set_ex(1'b0, 1'b1, 1'b0, 1'b1, 16'h0050, 16'h0, 4'd4, 3'b000);
    #1;
    check("inv_stall", 32'(stall), 32'd0);
    check("inv_valid", 32'(wb_valid), 32'd0);
    check("inv_rw", 32'(wb_reg_write), 32'd0);
    tick();
    check("err_sticky", 32'(mem_err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
